// File: rtl/pkt_mem_arbiter.sv
// pkt_mem_arbiter: round-robin arbiter sharing one packet-memory port among
// NUM_REQ requesters (index 0 = parser). Grants are combinational. The memory
// command and the read-return valid are registered.
// Optional feature macro: ARB_LOCK_EN (bus locking through req_lock_i).
module pkt_mem_arbiter #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_ce_i,
  input  logic [NUM_REQ-1:0]               req_we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [NUM_REQ*4-1:0]             req_width_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data_i,
`ifdef ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]               req_lock_i,
`endif
  output logic [NUM_REQ-1:0]               gnt_o,
  output logic [NUM_REQ-1:0]               rvalid_o,
  output logic [DATA_WIDTH-1:0]            rdata_o,
  output logic                             mem_ce_o,
  output logic                             mem_we_o,
  output logic [ADDR_WIDTH-1:0]            mem_addr_o,
  output logic [3:0]                       mem_width_o,
  output logic [DATA_WIDTH-1:0]            mem_data_o,
  input  logic [DATA_WIDTH-1:0]            mem_data_i
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   w_winner;
  logic               w_found;
  logic [NUM_REQ-1:0] w_req_eff;
  logic [NUM_REQ-1:0] w_gnt;
  logic [NUM_REQ-1:0] r_rd_tag;

`ifdef ARB_LOCK_EN
  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [PTR_W-1:0] r_lock_id;
  logic [PTR_W-1:0] w_lock_id_nxt;
`endif

  // Requests that may compete this cycle (only the lock owner while locked)
  always_comb begin
    w_req_eff = req_ce_i;
`ifdef ARB_LOCK_EN
    if (r_state == ARB_LOCKED) begin
      w_req_eff = req_ce_i & (NUM_REQ'(1) << r_lock_id);
    end
`endif
  end

  // Round-robin scan starting just after the last winner, wrapping to 0
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      if (!w_found && w_req_eff[PTR_W'((32'(r_rr_ptr) + i) % NUM_REQ)]) begin
        w_found  = 1'b1;
        w_winner = PTR_W'((32'(r_rr_ptr) + i) % NUM_REQ);
      end
    end
  end

  // One-hot grant, suppressed during reset
  always_comb begin
    w_gnt = '0;
    if (w_found && !rst) begin
      w_gnt = NUM_REQ'(1) << w_winner;
    end
  end

  assign gnt_o   = w_gnt;
  assign rdata_o = mem_data_i;

  // Issue the winning access to memory and track in-flight read owners
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= PTR_W'(NUM_REQ - 1);
      r_rd_tag    <= '0;
      rvalid_o    <= '0;
      mem_ce_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_width_o <= '0;
      mem_data_o  <= '0;
    end else begin
      rvalid_o <= r_rd_tag;
      r_rd_tag <= '0;
      mem_ce_o <= w_found;
      if (w_found) begin
        r_rr_ptr    <= w_winner;
        mem_we_o    <= req_we_i[w_winner];
        mem_addr_o  <= req_addr_i[32'(w_winner)*ADDR_WIDTH +: ADDR_WIDTH];
        mem_width_o <= req_width_i[32'(w_winner)*4 +: 4];
        mem_data_o  <= req_data_i[32'(w_winner)*DATA_WIDTH +: DATA_WIDTH];
        if (!req_we_i[w_winner]) begin
          r_rd_tag <= w_gnt;
        end
      end
    end
  end

`ifdef ARB_LOCK_EN
  // Lock state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ARB_IDLE;
      r_lock_id <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lock_id <= w_lock_id_nxt;
    end
  end

  // Lock next-state: a locking grant enters LOCKED, a non-locking grant to the owner leaves it
  always_comb begin
    w_state_nxt   = r_state;
    w_lock_id_nxt = r_lock_id;
    case (r_state)
      ARB_IDLE: begin
        if (w_found && req_lock_i[w_winner]) begin
          w_state_nxt   = ARB_LOCKED;
          w_lock_id_nxt = w_winner;
        end
      end
      ARB_LOCKED: begin
        if (w_found && !req_lock_i[w_winner]) begin
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end
`endif

endmodule

// File: tb/tb_pkt_mem_arbiter.sv
// tb_pkt_mem_arbiter: directed vectors for pkt_mem_arbiter (NUM_REQ=3).
// The lock scenario is compiled in when ARB_LOCK_EN is defined.
module tb_pkt_mem_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req_ce;
  logic [NR-1:0]     req_we;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*4-1:0]   req_width;
  logic [NR*DW-1:0]  req_data;
`ifdef ARB_LOCK_EN
  logic [NR-1:0]     req_lock;
`endif
  logic [NR-1:0]     gnt;
  logic [NR-1:0]     rvalid;
  logic [DW-1:0]     rdata;
  logic              mem_ce;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [3:0]        mem_width;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  pkt_mem_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_ce_i    (req_ce),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_width_i (req_width),
    .req_data_i  (req_data),
`ifdef ARB_LOCK_EN
    .req_lock_i  (req_lock),
`endif
    .gnt_o       (gnt),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .mem_ce_o    (mem_ce),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_width_o (mem_width),
    .mem_data_o  (mem_wdata),
    .mem_data_i  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it does not match
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Load the request fields of requester k
  task automatic set_req(input int k, input logic we, input logic [AW-1:0] a,
                         input logic [3:0] w, input logic [DW-1:0] d);
    req_we[k]            = we;
    req_addr[k*AW +: AW] = a;
    req_width[k*4 +: 4]  = w;
    req_data[k*DW +: DW] = d;
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    req_ce = '0;
    tick();
    rst    = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_ce    = '0;
    req_we    = '0;
    req_addr  = '0;
    req_width = '0;
    req_data  = '0;
    mem_rdata = '0;
`ifdef ARB_LOCK_EN
    req_lock  = '0;
`endif

    // Reset values; grants held off while rst is high
    tick();
    tick();
    req_ce = 3'b111;
    #1;
    check_eq("rst_gnt", 64'(gnt), 64'(3'b000));
    check_eq("rst_mem_ce", 64'(mem_ce), 64'(1'b0));
    check_eq("rst_mem_we", 64'(mem_we), 64'(1'b0));
    check_eq("rst_mem_addr", 64'(mem_addr), 64'h0);
    check_eq("rst_mem_width", 64'(mem_width), 64'h0);
    check_eq("rst_mem_data", 64'(mem_wdata), 64'h0);
    check_eq("rst_rvalid", 64'(rvalid), 64'(3'b000));
    req_ce = '0;
    tick();
    rst = 1'b0;

    // Single read from requester 0
    set_req(0, 1'b0, 32'd12, 4'd4, 32'h0);
    req_ce = 3'b001;
    #1;
    check_eq("t1_gnt", 64'(gnt), 64'(3'b001));
    tick();
    req_ce = '0;
    check_eq("t1_mem_ce", 64'(mem_ce), 64'(1'b1));
    check_eq("t1_mem_we", 64'(mem_we), 64'(1'b0));
    check_eq("t1_mem_addr", 64'(mem_addr), 64'd12);
    check_eq("t1_mem_width", 64'(mem_width), 64'd4);
    check_eq("t1_rvalid_n1", 64'(rvalid), 64'(3'b000));
    mem_rdata = 32'h0800_0001;
    #1;
    check_eq("t1_gnt_idle", 64'(gnt), 64'(3'b000));
    tick();
    check_eq("t1_rvalid", 64'(rvalid), 64'(3'b001));
    check_eq("t1_rdata", 64'(rdata), 64'h0800_0001);
    mem_rdata = '0;
    tick();
    check_eq("t1_rvalid_clr", 64'(rvalid), 64'(3'b000));

    // All three requesters reading continuously for 6 grants
    do_reset();
    for (int k = 0; k < 3; k++) set_req(k, 1'b0, 32'h100 + 32'(4 * k), 4'd4, 32'h0);
    req_ce = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      check_eq($sformatf("t2_gnt%0d", c), 64'(gnt), 64'(3'b001 << (c % 3)));
      tick();
      if (c == 5) req_ce = '0;
      check_eq($sformatf("t2_ce%0d", c), 64'(mem_ce), 64'(1'b1));
      check_eq($sformatf("t2_addr%0d", c), 64'(mem_addr), 64'(32'h100 + 32'(4 * (c % 3))));
      if (c >= 1)
        check_eq($sformatf("t2_rvalid%0d", c), 64'(rvalid), 64'(3'b001 << ((c - 1) % 3)));
    end
    #1;
    check_eq("t2_gnt_end", 64'(gnt), 64'(3'b000));
    tick();
    check_eq("t2_ce_end", 64'(mem_ce), 64'(1'b0));
    check_eq("t2_rvalid_end", 64'(rvalid), 64'(3'b100));

    // Wrap: last winner was 2, so requester 0 beats requester 2
    set_req(0, 1'b1, 32'h200, 4'd4, 32'h1111_1111);
    set_req(2, 1'b1, 32'h208, 4'd4, 32'h2222_2222);
    req_ce = 3'b101;
    #1;
    check_eq("t4_gnt_first", 64'(gnt), 64'(3'b001));
    tick();
    req_ce = 3'b100;
    check_eq("t4_addr_first", 64'(mem_addr), 64'h200);
    #1;
    check_eq("t4_gnt_second", 64'(gnt), 64'(3'b100));
    tick();
    req_ce = '0;
    check_eq("t4_addr_second", 64'(mem_addr), 64'h208);
    check_eq("t4_data_second", 64'(mem_wdata), 64'h2222_2222);

    // Write from requester 2: no rvalid, fields hold on the idle cycle after
    set_req(2, 1'b1, 32'h40, 4'd4, 32'hDEAD_BEEF);
    req_ce = 3'b100;
    #1;
    check_eq("t3_gnt", 64'(gnt), 64'(3'b100));
    tick();
    req_ce = '0;
    check_eq("t3_mem_ce", 64'(mem_ce), 64'(1'b1));
    check_eq("t3_mem_we", 64'(mem_we), 64'(1'b1));
    check_eq("t3_mem_addr", 64'(mem_addr), 64'h40);
    check_eq("t3_mem_data", 64'(mem_wdata), 64'hDEAD_BEEF);
    check_eq("t3_rvalid_n1", 64'(rvalid), 64'(3'b000));
    tick();
    check_eq("t3_rvalid_n2", 64'(rvalid), 64'(3'b000));
    check_eq("t3_ce_idle", 64'(mem_ce), 64'(1'b0));
    check_eq("t3_addr_hold", 64'(mem_addr), 64'h40);
    check_eq("t3_we_hold", 64'(mem_we), 64'(1'b1));

    // Reset one cycle after a read from requester 1 is issued
    set_req(1, 1'b0, 32'h80, 4'd2, 32'h0);
    req_ce = 3'b010;
    #1;
    check_eq("t5_gnt", 64'(gnt), 64'(3'b010));
    tick();
    check_eq("t5_mem_ce", 64'(mem_ce), 64'(1'b1));
    check_eq("t5_mem_width", 64'(mem_width), 64'd2);
    rst    = 1'b1;
    req_ce = 3'b001;
    #1;
    check_eq("t5_gnt_in_rst", 64'(gnt), 64'(3'b000));
    tick();
    check_eq("t5_rvalid_drop", 64'(rvalid), 64'(3'b000));
    check_eq("t5_mem_ce_rst", 64'(mem_ce), 64'(1'b0));
    check_eq("t5_mem_addr_rst", 64'(mem_addr), 64'h0);
    rst    = 1'b0;
    req_ce = 3'b110;
    #1;
    check_eq("t5_gnt_after", 64'(gnt), 64'(3'b010));
    tick();
    req_ce = '0;
    check_eq("t5_rvalid_n1", 64'(rvalid), 64'(3'b000));
    check_eq("t5_mem_ce_after", 64'(mem_ce), 64'(1'b1));
    tick();
    check_eq("t5_rvalid_new", 64'(rvalid), 64'(3'b010));

`ifdef ARB_LOCK_EN
    // Requester 1 locks for three reads while requester 0 keeps requesting
    do_reset();
    set_req(0, 1'b1, 32'h300, 4'd4, 32'h0);
    req_ce = 3'b001;
    #1;
    check_eq("t6_gnt_pre", 64'(gnt), 64'(3'b001));
    tick();
    set_req(1, 1'b0, 32'h310, 4'd4, 32'h0);
    req_ce   = 3'b011;
    req_lock = 3'b010;
    #1;
    check_eq("t6_gnt_lock1", 64'(gnt), 64'(3'b010));
    tick();
    #1;
    check_eq("t6_gnt_lock2", 64'(gnt), 64'(3'b010));
    tick();
    req_lock = 3'b000;
    #1;
    check_eq("t6_gnt_lock3", 64'(gnt), 64'(3'b010));
    tick();
    req_ce = 3'b001;
    #1;
    check_eq("t6_gnt_after", 64'(gnt), 64'(3'b001));
    tick();
    req_ce = '0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
